// File: rtl/nand_stim_check_if.sv
// Signal bundle between the NAND stimulus/checker and its environment.
// master: the checker (drives gate inputs and results); slave: the gate/controller side.
interface nand_stim_check_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/nand_stim_check.sv
// Applies the four input vectors to a 2-input NAND under test, holds each for HOLD_CYCLES,
// samples y at the end of each hold window and records mismatches.
module nand_stim_check #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input logic                clk,
  input logic                rst,
  nand_stim_check_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  localparam logic [7:0] LastCnt = 8'(HOLD_CYCLES - 1);

  state_e     r_state, w_state_nxt;
  logic [1:0] r_vec, w_vec_nxt;
  logic [7:0] r_hcnt, w_hcnt_nxt;
  logic [2:0] r_err, w_err_nxt;
  logic [3:0] r_fail, w_fail_nxt;
  logic       r_pass, w_pass_nxt;
  logic       w_expected;
  logic       w_mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_vec   <= 2'd0;
      r_hcnt  <= 8'd0;
      r_err   <= 3'd0;
      r_fail  <= 4'd0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_err   <= w_err_nxt;
      r_fail  <= w_fail_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // Case-inequality so an X/Z on y counts as a mismatch.
  assign w_expected = ~(r_vec[1] & r_vec[0]);
  assign w_mismatch = (bus.y !== w_expected);

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_hcnt_nxt  = r_hcnt;
    w_err_nxt   = r_err;
    w_fail_nxt  = r_fail;
    w_pass_nxt  = r_pass;
    unique case (r_state)
      StIdle, StDone: begin
        if (bus.start) begin
          w_state_nxt = StDrive;
          w_vec_nxt   = 2'd0;
          w_hcnt_nxt  = 8'd0;
          w_err_nxt   = 3'd0;
          w_fail_nxt  = 4'd0;
          w_pass_nxt  = 1'b0;
        end
      end
      StDrive: begin
        if (r_hcnt == LastCnt) begin
          if (w_mismatch) begin
            w_fail_nxt[r_vec] = 1'b1;
            w_err_nxt         = r_err + 3'd1;
          end
          w_hcnt_nxt = 8'd0;
          if (r_vec == 2'd3) begin
            w_state_nxt = StDone;
            w_pass_nxt  = (w_err_nxt == 3'd0);
          end else begin
            w_vec_nxt = r_vec + 2'd1;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + 8'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // vec stays at 3 through DONE, so a/b hold 1,1 there and are 0 in IDLE.
  assign bus.a         = r_vec[1];
  assign bus.b         = r_vec[0];
  assign bus.busy      = (r_state == StDrive);
  assign bus.done      = (r_state == StDone);
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.fail_vec  = r_fail;

endmodule
